// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU pipeline and a 16-bit halfword memory.
// Splits byte/half/word requests into halfword cycles; byte stores use read-modify-write.
module mem_access_unit #(
  parameter int ADDRWIDTH = 20,
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sext,
  input  logic [ADDRWIDTH:0]   addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic                 mem_write_n,
  output logic                 mem_enable_n,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_in,
  input  logic [DATAWIDTH-1:0] mem_out
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [ADDRWIDTH-1:0] HW_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    WR_LO  = 3'd3,
    WR_HI  = 3'd4,
    RMW_RD = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t                 state_r, state_next_s;
  logic                   we_r, sext_r, byte_sel_r;
  logic [1:0]             size_r;
  logic [ADDRWIDTH-1:0]   hw_addr_r;
  logic [31:0]            wdata_r, rdata_r;
  logic [DATAWIDTH-1:0]   cap_r;
  logic                   done_r, err_r;
  logic                   accept_s, bad_req_s;
  logic                   mem_write_n_s, mem_enable_n_s;
  logic [ADDRWIDTH-1:0]   mem_addr_s;
  logic [DATAWIDTH-1:0]   mem_in_s;

  function automatic logic is_bad_req(input logic [1:0] sz, input logic [1:0] a_lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a_lo[0];
      SZ_WORD: bad = (a_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [15:0] hw, input logic is_byte,
                                              input logic hi_sel, input logic sx);
    logic [7:0]  b;
    logic [31:0] res;
    b = hi_sel ? hw[15:8] : hw[7:0];
    if (is_byte) begin
      res = sx ? {{24{b[7]}}, b} : {24'h000000, b};
    end else begin
      res = sx ? {{16{hw[15]}}, hw} : {16'h0000, hw};
    end
    return res;
  endfunction

  function automatic logic [15:0] merge_byte(input logic [15:0] hw, input logic [7:0] b,
                                             input logic hi_sel);
    return hi_sel ? {b, hw[7:0]} : {hw[15:8], b};
  endfunction

  assign accept_s  = (state_r == IDLE) && req;
  assign bad_req_s = is_bad_req(size, addr[1:0]);

  // Next-state sequencing; requests outside IDLE are ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req) begin
          state_next_s = IDLE;
        end else if (bad_req_s) begin
          state_next_s = RESP;
        end else if (!we) begin
          state_next_s = RD_LO;
        end else if (size == SZ_BYTE) begin
          state_next_s = RMW_RD;
        end else begin
          state_next_s = WR_LO;
        end
      end
      RD_LO:   state_next_s = (size_r == SZ_WORD) ? RD_HI : RESP;
      RD_HI:   state_next_s = RESP;
      WR_LO:   state_next_s = (size_r == SZ_WORD) ? WR_HI : RESP;
      WR_HI:   state_next_s = RESP;
      RMW_RD:  state_next_s = WR_LO;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Memory strobes and bus decoded from state and latched operands only.
  always_comb begin
    mem_write_n_s  = 1'b1;
    mem_enable_n_s = 1'b1;
    mem_addr_s     = '0;
    mem_in_s       = '0;
    case (state_r)
      RD_LO, RMW_RD: begin
        mem_enable_n_s = 1'b0;
        mem_addr_s     = hw_addr_r;
      end
      RD_HI: begin
        mem_enable_n_s = 1'b0;
        mem_addr_s     = hw_addr_r + HW_ONE;
      end
      WR_LO: begin
        mem_write_n_s = 1'b0;
        mem_addr_s    = hw_addr_r;
        mem_in_s      = (size_r == SZ_BYTE) ? merge_byte(cap_r, wdata_r[7:0], byte_sel_r)
                                            : wdata_r[15:0];
      end
      WR_HI: begin
        mem_write_n_s = 1'b0;
        mem_addr_s    = hw_addr_r + HW_ONE;
        mem_in_s      = wdata_r[31:16];
      end
      default: begin
        mem_write_n_s  = 1'b1;
        mem_enable_n_s = 1'b1;
      end
    endcase
  end

  // State register, operand latch, read capture and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      sext_r     <= 1'b0;
      byte_sel_r <= 1'b0;
      size_r     <= 2'b00;
      hw_addr_r  <= '0;
      wdata_r    <= 32'h0000_0000;
      cap_r      <= '0;
      rdata_r    <= 32'h0000_0000;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == RESP);
      err_r   <= accept_s && bad_req_s;
      if (accept_s) begin
        we_r       <= we;
        sext_r     <= sext;
        byte_sel_r <= addr[0];
        size_r     <= size;
        hw_addr_r  <= addr[ADDRWIDTH:1];
        wdata_r    <= wdata;
      end
      if ((state_r == RD_LO) || (state_r == RMW_RD)) begin
        cap_r <= mem_out;
      end
      if ((state_r == RD_LO) && (size_r != SZ_WORD)) begin
        rdata_r <= load_extend(mem_out, size_r == SZ_BYTE, byte_sel_r, sext_r);
      end else if (state_r == RD_HI) begin
        rdata_r <= {mem_out, cap_r};
      end
    end
  end

  assign rdata        = rdata_r;
  assign done         = done_r;
  assign err          = err_r;
  assign busy         = (state_r != IDLE);
  assign mem_write_n  = mem_write_n_s;
  assign mem_enable_n = mem_enable_n_s;
  assign mem_addr     = mem_addr_s;
  assign mem_in       = mem_in_s;

  logic unused_s;
  assign unused_s = we_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: halfword memory model, transaction-level
// reference model and a per-cycle compare process.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n, req, we, sext;
  logic [1:0]  size;
  logic [20:0] addr;
  logic [31:0] wdata, rdata;
  logic        done, err, busy, mem_write_n, mem_enable_n;
  logic [19:0] mem_addr;
  logic [15:0] mem_in, mem_out;

  logic [15:0] mem     [0:1048575];
  logic [15:0] ref_mem [0:1048575];
  logic        pl_en = 1'b0;
  logic [19:0] pl_addr = 20'h0;
  logic [15:0] pl_data = 16'h0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exp_done_at = -1;
  int last_done_cyc = -100;
  bit cur_err = 1'b0;
  bit pend_valid = 1'b0;
  bit chk_en = 1'b0;
  bit in_win_c, at_done_c;
  logic [31:0] pend_rdata = 32'h0;
  logic [31:0] rdata_m = 32'h0;

  mem_access_unit #(.ADDRWIDTH(20), .DATAWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_write_n(mem_write_n), .mem_enable_n(mem_enable_n), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_out = mem_enable_n ? 16'hA5A5 : mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!mem_write_n) mem[mem_addr] <= mem_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      rdata_m = 32'h0;
    end else if (chk_en) begin
      in_win_c  = (cyc > acc_cyc) && (cyc <= exp_done_at);
      at_done_c = (cyc == exp_done_at);
      if (at_done_c && pend_valid) rdata_m = pend_rdata;
      if (done) last_done_cyc = cyc;
      chk("done", {31'b0, done}, {31'b0, at_done_c});
      chk("err", {31'b0, err}, {31'b0, at_done_c && cur_err});
      chk("busy", {31'b0, busy}, {31'b0, in_win_c});
      chk("rdata", rdata, rdata_m);
      chk("strobe_overlap", {31'b0, !mem_write_n && !mem_enable_n}, 32'h0);
      if (!in_win_c || cur_err) chk("strobes_idle", {30'b0, mem_write_n, mem_enable_n}, 32'h3);
      if (mem_write_n) chk("mem_in_idle", {16'h0, mem_in}, 32'h0);
    end
  end

  // Called just after a negedge; writes one halfword into both memories.
  task automatic preload(input int h, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = h[19:0]; pl_data = d; ref_mem[h] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and predict its outcome from the access rules.
  task automatic run_req(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [20:0] a, input logic [31:0] wd, input int hold);
    int h, lat;
    bit e;
    logic [15:0] hw;
    logic [7:0]  b;
    h = int'(a[20:1]);
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    #1;
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    pend_valid = 1'b0;
    if (e) lat = 1;
    else if (sz == 2'b01) lat = 2;
    else if (sz == 2'b00) lat = w ? 3 : 2;
    else lat = 3;
    if (!e && !w) begin
      pend_valid = 1'b1;
      hw = ref_mem[h];
      b  = a[0] ? hw[15:8] : hw[7:0];
      if (sz == 2'b10) pend_rdata = {ref_mem[h+1], hw};
      else if (sz == 2'b01) pend_rdata = sx ? {{16{hw[15]}}, hw} : {16'h0, hw};
      else pend_rdata = sx ? {{24{b[7]}}, b} : {24'h0, b};
    end else if (!e) begin
      if (sz == 2'b10) begin
        ref_mem[h] = wd[15:0]; ref_mem[h+1] = wd[31:16];
      end else if (sz == 2'b01) begin
        ref_mem[h] = wd[15:0];
      end else begin
        hw = ref_mem[h];
        if (a[0]) hw[15:8] = wd[7:0]; else hw[7:0] = wd[7:0];
        ref_mem[h] = hw;
      end
    end
    cur_err = e;
    acc_cyc = cyc;
    exp_done_at = cyc + lat;
    for (int k = 0; k <= hold; k++) @(negedge clk);
    #1;
    req = 1'b0; we = $urandom_range(0, 1); size = $urandom_range(0, 3);
    addr = $urandom; wdata = $urandom; sext = $urandom_range(0, 1);
    while (cyc <= exp_done_at) @(negedge clk);
    if (!e && w) begin
      chk("mem_lo", {16'h0, mem[h]}, {16'h0, ref_mem[h]});
      if (sz == 2'b10) chk("mem_hi", {16'h0, mem[h+1]}, {16'h0, ref_mem[h+1]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rsz;
    logic [20:0] ra;
    int r;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 21'h0; wdata = 32'h0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_write_n", {31'b0, mem_write_n}, 32'h1);
    chk("rst_enable_n", {31'b0, mem_enable_n}, 32'h1);
    chk("rst_mem_addr", {12'h0, mem_addr}, 32'h0);
    chk("rst_mem_in", {16'h0, mem_in}, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(i, 16'($urandom));
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Word store then word load.
    run_req(1, 2'b10, 0, 21'h00010, 32'hDEADBEEF, 0);
    chk("ws_lat", last_done_cyc - acc_cyc, 3);
    chk("ws_hw8", {16'h0, mem[8]}, 32'h0000BEEF);
    chk("ws_hw9", {16'h0, mem[9]}, 32'h0000DEAD);
    run_req(0, 2'b10, 0, 21'h00010, 32'h0, 0);
    chk("wl_lat", last_done_cyc - acc_cyc, 3);
    chk("wl_rdata", rdata, 32'hDEADBEEF);

    // Byte store via read-modify-write, then byte loads.
    preload(32'h20, 16'h1234);
    run_req(1, 2'b00, 0, 21'h00041, 32'h000000AB, 0);
    chk("bs_lat", last_done_cyc - acc_cyc, 3);
    chk("bs_hw20", {16'h0, mem[32'h20]}, 32'h0000AB34);
    run_req(0, 2'b00, 1, 21'h00041, 32'h0, 0);
    chk("bl_sext", rdata, 32'hFFFFFFAB);
    chk("bl_lat", last_done_cyc - acc_cyc, 2);
    run_req(0, 2'b00, 0, 21'h00041, 32'h0, 0);
    chk("bl_zext", rdata, 32'h000000AB);
    run_req(0, 2'b00, 1, 21'h00040, 32'h0, 0);
    chk("bl_lo", rdata, 32'h00000034);

    // Error requests: one-cycle response, no memory cycle, rdata held.
    run_req(0, 2'b10, 0, 21'h00002, 32'h0, 0);
    chk("err_w_lat", last_done_cyc - acc_cyc, 1);
    run_req(1, 2'b01, 0, 21'h00003, 32'h5555, 0);
    chk("err_h_lat", last_done_cyc - acc_cyc, 1);
    run_req(0, 2'b11, 1, 21'h00010, 32'h0, 0);
    chk("err_r_lat", last_done_cyc - acc_cyc, 1);
    chk("err_rdata", rdata, 32'h00000034);
    chk("err_hw1", {16'h0, mem[1]}, {16'h0, ref_mem[1]});

    // req held through the whole access, then an immediate follow-up.
    run_req(0, 2'b10, 0, 21'h00010, 32'h0, 3);
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    run_req(0, 2'b01, 1, 21'h00012, 32'h0, 0);
    chk("hold_next", rdata, 32'hFFFFDEAD);

    // Word at the top of the address space.
    run_req(1, 2'b10, 0, 21'h1FFFFC, 32'h13579BDF, 0);
    run_req(0, 2'b10, 0, 21'h1FFFFC, 32'h0, 0);
    chk("top_rdata", rdata, 32'h13579BDF);

    // Randomized mix.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      rsz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      ra = 21'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'b01) ra[0] = 1'b0;
        if (rsz == 2'b10) ra[1:0] = 2'b00;
      end
      run_req($urandom_range(0, 1), rsz, $urandom_range(0, 1), ra, $urandom,
              $urandom_range(0, 1));
    end

    // Reset during the high half of a word store.
    preload(24, 16'h5555);
    preload(25, 16'h5555);
    #1;
    we = 1'b1; size = 2'b10; sext = 1'b0; addr = 21'h00030; wdata = 32'hCAFEF00D; req = 1'b1;
    cur_err = 1'b0; pend_valid = 1'b0; acc_cyc = cyc; exp_done_at = cyc + 3;
    @(negedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    #2;
    chk("wrhi_strobe", {31'b0, mem_write_n}, 32'h0);
    chk("wrhi_addr", {12'h0, mem_addr}, 32'h00000019);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_write_n", {31'b0, mem_write_n}, 32'h1);
    chk("abort_enable_n", {31'b0, mem_enable_n}, 32'h1);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_hw_lo", {16'h0, mem[24]}, 32'h0000F00D);
    chk("abort_hw_hi", {16'h0, mem[25]}, 32'h00005555);
    ref_mem[24] = 16'hF00D;
    exp_done_at = -1;
    acc_cyc = cyc;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    run_req(0, 2'b10, 0, 21'h00030, 32'h0, 0);
    chk("post_abort_rdata", rdata, 32'h5555F00D);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
